// File: rtl/rob_commit_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : rob_commit_ctrl_if
//  Brief    : Allocate / writeback / query / commit bundle for the ROB.
//  Revision : 1.0  initial release
// ============================================================================
interface rob_commit_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             alloc_valid;
    logic [4:0]       alloc_reg_dest;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;

    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             wb_mispredict;
    logic [31:0]      wb_target;

    logic [TAG_W-1:0] q1_tag;
    logic [TAG_W-1:0] q2_tag;
    logic             q1_ready;
    logic             q2_ready;
    logic [31:0]      q1_data;
    logic [31:0]      q2_data;

    logic             commit_valid;
    logic [4:0]       commit_reg_dest;
    logic [TAG_W-1:0] commit_tag;
    logic [31:0]      commit_data;
    logic             clear;
    logic [31:0]      redirect_pc;

    modport master (
        output alloc_valid, alloc_reg_dest,
        output wb_valid, wb_tag, wb_data, wb_mispredict, wb_target,
        output q1_tag, q2_tag,
        input  alloc_ready, alloc_tag,
        input  q1_ready, q2_ready, q1_data, q2_data,
        input  commit_valid, commit_reg_dest, commit_tag, commit_data,
        input  clear, redirect_pc
    );

    modport slave (
        input  alloc_valid, alloc_reg_dest,
        input  wb_valid, wb_tag, wb_data, wb_mispredict, wb_target,
        input  q1_tag, q2_tag,
        output alloc_ready, alloc_tag,
        output q1_ready, q2_ready, q1_data, q2_data,
        output commit_valid, commit_reg_dest, commit_tag, commit_data,
        output clear, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rob_commit_ctrl
//  Brief    : Reorder buffer with in-order commit and mispredict flush.
//  Revision : 1.0  initial release
// ============================================================================
module rob_commit_ctrl #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy_i,
    rob_commit_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [TAG_W:0]   c_depth   = ROB_DEPTH[TAG_W:0];
    localparam logic [TAG_W:0]   c_cnt_one = {{TAG_W{1'b0}}, 1'b1};
    localparam logic [TAG_W-1:0] c_ptr_one = {{(TAG_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [TAG_W-1:0]       head_q, tail_q;
    logic [TAG_W:0]         count_q;

    logic [ROB_DEPTH-1:0]   busy_q, done_q, mis_q;
    logic [4:0]             dest_q   [ROB_DEPTH];
    logic [31:0]            data_q   [ROB_DEPTH];
    logic [31:0]            target_q [ROB_DEPTH];

    logic                   commit_valid_q;
    logic [4:0]             commit_dest_q;
    logic [TAG_W-1:0]       commit_tag_q;
    logic [31:0]            commit_data_q;
    logic [31:0]            redirect_pc_q;

    logic w_alloc_ready, w_do_alloc, w_do_wb, w_do_commit, w_do_drain, w_head_ready;

    always_comb begin
        state_d      = state_q;
        w_do_commit  = 1'b0;
        w_do_drain   = 1'b0;
        w_head_ready = busy_q[head_q] & done_q[head_q];
        // No early free: a slot retired this cycle only becomes usable next cycle
        w_alloc_ready = (count_q < c_depth) && (state_q == ST_RUN);
        w_do_alloc    = bus.alloc_valid && w_alloc_ready;
        w_do_wb       = bus.wb_valid && (state_q == ST_RUN) && busy_q[bus.wb_tag];
        case (state_q)
            ST_RUN: begin
                if (w_head_ready) begin
                    w_do_commit = 1'b1;
                    if (mis_q[head_q]) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_do_drain = 1'b1;
                state_d    = ST_FLUSH;
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            done_q         <= '0;
            mis_q          <= '0;
            commit_valid_q <= 1'b0;
            commit_dest_q  <= '0;
            commit_tag_q   <= '0;
            commit_data_q  <= '0;
            redirect_pc_q  <= '0;
        end else if (rdy_i) begin
            state_q        <= state_d;
            commit_valid_q <= w_do_commit;
            if (w_do_commit) begin
                commit_dest_q <= dest_q[head_q];
                commit_tag_q  <= head_q;
                commit_data_q <= data_q[head_q];
                if (mis_q[head_q]) redirect_pc_q <= target_q[head_q];
            end

            if (w_do_drain) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                busy_q  <= '0;
                done_q  <= '0;
            end else begin
                // Head and tail only coincide when empty or full, so these never collide
                if (w_do_alloc) begin
                    busy_q[tail_q] <= 1'b1;
                    done_q[tail_q] <= 1'b0;
                    mis_q[tail_q]  <= 1'b0;
                    dest_q[tail_q] <= bus.alloc_reg_dest;
                    tail_q         <= tail_q + c_ptr_one;
                end
                if (w_do_wb) begin
                    done_q[bus.wb_tag]   <= 1'b1;
                    mis_q[bus.wb_tag]    <= bus.wb_mispredict;
                    data_q[bus.wb_tag]   <= bus.wb_data;
                    target_q[bus.wb_tag] <= bus.wb_target;
                end
                if (w_do_commit) begin
                    busy_q[head_q] <= 1'b0;
                    head_q         <= head_q + c_ptr_one;
                end
                case ({w_do_alloc, w_do_commit})
                    2'b10:   count_q <= count_q + c_cnt_one;
                    2'b01:   count_q <= count_q - c_cnt_one;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign bus.alloc_ready     = w_alloc_ready;
    assign bus.alloc_tag       = tail_q;
    assign bus.q1_ready        = (bus.wb_valid && bus.wb_tag == bus.q1_tag) ||
                                 (busy_q[bus.q1_tag] & done_q[bus.q1_tag]);
    assign bus.q1_data         = (bus.wb_valid && bus.wb_tag == bus.q1_tag) ?
                                 bus.wb_data : data_q[bus.q1_tag];
    assign bus.q2_ready        = (bus.wb_valid && bus.wb_tag == bus.q2_tag) ||
                                 (busy_q[bus.q2_tag] & done_q[bus.q2_tag]);
    assign bus.q2_data         = (bus.wb_valid && bus.wb_tag == bus.q2_tag) ?
                                 bus.wb_data : data_q[bus.q2_tag];
    assign bus.commit_valid    = commit_valid_q;
    assign bus.commit_reg_dest = commit_dest_q;
    assign bus.commit_tag      = commit_tag_q;
    assign bus.commit_data     = commit_data_q;
    assign bus.clear           = (state_q == ST_FLUSH);
    assign bus.redirect_pc     = redirect_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rob_commit_ctrl
//  Brief    : Scoreboard bench for rob_commit_ctrl commit order and flush.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rob_commit_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;

    rob_commit_ctrl_if #(.TAG_W(4)) bus ();

    rob_commit_ctrl #(.ROB_DEPTH(16), .TAG_W(4)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .rdy_i (rdy),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  dest;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] plan_data [16];
    logic [3:0]  m_tail = '0;
    logic [31:0] exp_redirect = '0;
    int          fl_stage = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
        m_tail   = '0;
        fl_stage = 0;
    endtask

    task automatic do_alloc(input logic [4:0] dest, input logic [31:0] data);
        exp_t e;
        chk_val("alloc_ready", {31'd0, bus.alloc_ready}, 32'd1);
        chk_val("alloc_tag", {28'd0, bus.alloc_tag}, {28'd0, m_tail});
        bus.alloc_valid    = 1'b1;
        bus.alloc_reg_dest = dest;
        e.tag = m_tail; e.dest = dest; e.data = data; e.mis = 1'b0;
        sb.push_back(e);
        plan_data[m_tail] = data;
        m_tail = m_tail + 4'd1;
        tick();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [3:0] tag, input logic mis, input logic [31:0] target);
        bus.wb_valid      = 1'b1;
        bus.wb_tag        = tag;
        bus.wb_data       = plan_data[tag];
        bus.wb_mispredict = mis;
        bus.wb_target     = target;
        if (mis) begin
            exp_redirect = target;
            foreach (sb[i]) if (sb[i].tag == tag) sb[i].mis = 1'b1;
        end
        tick();
        bus.wb_valid      = 1'b0;
        bus.wb_mispredict = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (sb.size() == 0 && fl_stage == 0) break;
            tick();
        end
        chk_val("idle_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Commit monitor: a commit is consumed on the edge that sees rdy high
    always @(negedge clk) begin
        if (!rst && rdy) begin
            if (fl_stage == 1) begin
                chk_val("flush_clear", {31'd0, bus.clear}, 32'd1);
                chk_val("flush_no_commit", {31'd0, bus.commit_valid}, 32'd0);
                chk_val("redirect_pc", bus.redirect_pc, exp_redirect);
                sb.delete();
                fl_stage = 2;
            end else if (fl_stage == 2) begin
                chk_val("clear_one_cycle", {31'd0, bus.clear}, 32'd0);
                fl_stage = 0;
            end else if (bus.commit_valid) begin
                if (sb.size() == 0) begin
                    chk_val("unexp_commit", {31'd0, bus.commit_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk_val("commit_tag", {28'd0, bus.commit_tag}, {28'd0, e.tag});
                    chk_val("commit_dest", {27'd0, bus.commit_reg_dest}, {27'd0, e.dest});
                    chk_val("commit_data", bus.commit_data, e.data);
                    if (e.mis) fl_stage = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.alloc_valid = 1'b0; bus.alloc_reg_dest = '0;
        bus.wb_valid = 1'b0; bus.wb_tag = '0; bus.wb_data = '0;
        bus.wb_mispredict = 1'b0; bus.wb_target = '0;
        bus.q1_tag = '0; bus.q2_tag = '0;
        do_reset();

        // Reset state
        chk_val("rst_alloc_ready", {31'd0, bus.alloc_ready}, 32'd1);
        chk_val("rst_alloc_tag", {28'd0, bus.alloc_tag}, 32'd0);
        chk_val("rst_commit_valid", {31'd0, bus.commit_valid}, 32'd0);
        chk_val("rst_clear", {31'd0, bus.clear}, 32'd0);
        chk_val("rst_redirect", bus.redirect_pc, 32'd0);

        // Out-of-order writeback, in-order commit
        do_alloc(5'd5, 32'hA);
        do_alloc(5'd6, 32'hB);
        do_alloc(5'd7, 32'hC);
        do_wb(4'd2, 1'b0, 32'd0);
        do_wb(4'd0, 1'b0, 32'd0);
        do_wb(4'd1, 1'b0, 32'd0);
        wait_idle(20);

        // Full, then wrap
        do_reset();
        for (int i = 0; i < 16; i++) do_alloc(5'(i + 1), 32'h100 + i);
        chk_val("full_not_ready", {31'd0, bus.alloc_ready}, 32'd0);
        do_wb(4'd0, 1'b0, 32'd0);
        chk_val("full_wb_not_ready", {31'd0, bus.alloc_ready}, 32'd0);
        tick();
        chk_val("wrap_ready", {31'd0, bus.alloc_ready}, 32'd1);
        chk_val("wrap_tag", {28'd0, bus.alloc_tag}, 32'd0);
        for (int i = 1; i < 16; i++) do_wb(4'(i), 1'b0, 32'd0);
        wait_idle(40);

        // Mispredict flush
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(5'(i + 1), 32'h10 + i);
        do_wb(4'd1, 1'b1, 32'h100);
        do_wb(4'd2, 1'b0, 32'd0);
        do_wb(4'd3, 1'b0, 32'd0);
        do_wb(4'd0, 1'b0, 32'd0);
        wait_idle(20);
        repeat (4) tick();
        chk_val("post_flush_tag", {28'd0, bus.alloc_tag}, 32'd0);
        chk_val("post_flush_ready", {31'd0, bus.alloc_ready}, 32'd1);
        m_tail = '0;

        // Stall with a commit pending
        do_reset();
        do_alloc(5'd9, 32'h55);
        do_alloc(5'd10, 32'h66);
        do_wb(4'd0, 1'b0, 32'd0);
        do_wb(4'd1, 1'b0, 32'd0);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_val("stall_valid", {31'd0, bus.commit_valid}, 32'd1);
            chk_val("stall_tag", {28'd0, bus.commit_tag}, 32'd0);
            tick();
        end
        rdy = 1'b1;
        wait_idle(20);

        // Query bypass
        do_reset();
        do_alloc(5'd1, 32'h20);
        do_alloc(5'd2, 32'h21);
        do_alloc(5'd3, 32'h22);
        do_alloc(5'd4, 32'hDEAD);
        bus.q1_tag = 4'd3; bus.q2_tag = 4'd2;
        bus.wb_valid = 1'b1; bus.wb_tag = 4'd3; bus.wb_data = 32'hDEAD;
        bus.wb_mispredict = 1'b0;
        #1;
        chk_val("byp_q1_ready", {31'd0, bus.q1_ready}, 32'd1);
        chk_val("byp_q1_data", bus.q1_data, 32'hDEAD);
        chk_val("byp_q2_ready", {31'd0, bus.q2_ready}, 32'd0);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        chk_val("stored_q1_ready", {31'd0, bus.q1_ready}, 32'd1);
        chk_val("stored_q1_data", bus.q1_data, 32'hDEAD);
        do_wb(4'd0, 1'b0, 32'd0);
        do_wb(4'd1, 1'b0, 32'd0);
        do_wb(4'd2, 1'b0, 32'd0);
        wait_idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
